mano_io_unit: RTL

- Peripheral-side I/O unit for the Mano basic computer. It provides the INPR/OUTR registers, the FGI/FGO flags, the IEN flag and the interrupt request R to the CPU.
- On the device side it serialises OUTR onto a UART transmit line and deserialises a UART receive line into INPR.
- It is the responder end of the CPU's INP/OUT/SKI/SKO/ION/IOF I/O-instruction interface.

---
 rtl/mano_io_unit.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mano_io_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mano_io_unit                                                  |
// | Purpose  : Peripheral-side I/O unit for the Mano basic computer. Holds   |
// |            INPR/OUTR, the FGI/FGO/IEN flags and the registered interrupt |
// |            request R. OUTR is shifted out on a UART tx line; a UART rx   |
// |            line is deserialised into INPR. Frame: 1 start, 8 data (LSB   |
// |            first), 1 stop; each bit lasts CLKS_PER_BIT clocks.           |
// | Ports    : clk, rst_n            clock / async active-low reset          |
// |            inp_rd_i, inpr_o, fgi_o   INP handshake and input register    |
// |            out_wr_i, ac_low_i, fgo_o OUT handshake and CPU data          |
// |            ien_set_i, ien_clr_i, int_ack_i, ien_o, int_req_o  interrupt  |
// |            ovr_o, ferr_o         sticky overrun / framing-error pulse    |
// |            rx_i, tx_o            serial lines, idle high                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mano_io_unit #(
  parameter int CLKS_PER_BIT = 16,  // even, >= 4
  parameter int DATA_W       = 8    // fixed at 8 for Mano compatibility
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inp_rd_i,
  output logic [DATA_W-1:0] inpr_o,
  output logic              fgi_o,
  input  logic              out_wr_i,
  input  logic [DATA_W-1:0] ac_low_i,
  output logic              fgo_o,
  input  logic              ien_set_i,
  input  logic              ien_clr_i,
  input  logic              int_ack_i,
  output logic              ien_o,
  output logic              int_req_o,
  output logic              ovr_o,
  output logic              ferr_o,
  input  logic              rx_i,
  output logic              tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] C_DATA_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ------------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------------
  logic [1:0]        tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q,   tx_bit_d;
  logic [DATA_W-1:0] outr_q,     outr_d;
  logic              fgo_q,      fgo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      outr_q     <= '0;
      fgo_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      outr_q     <= outr_d;
      fgo_q      <= fgo_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    outr_d     = outr_q;
    fgo_d      = fgo_q;
    case (tx_state_q)
      S_IDLE: begin
        // fgo is only ever high in IDLE, so an OUT while busy is dropped here.
        if (out_wr_i && fgo_q) begin
          outr_d     = ac_low_i;
          fgo_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == C_DATA_LAST) begin
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == C_BIT_LAST) begin
          fgo_d      = 1'b1;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line level is a pure decode of registered state, so it follows the
  // state register without extra latency and returns high on reset.
  always_comb begin
    tx_o = 1'b1;
    case (tx_state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = outr_q[tx_bit_q];
      default: tx_o = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------------
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q,   rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q,   rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_fall;
  logic              rx_good;
  logic              rx_bad;

  // rx_prev_q is the previous synchronised level; a falling edge therefore
  // needs the line to have been seen high first, which is what re-arms the
  // receiver after a frame whose stop bit was low.
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        // Half-bit check: a line already back high is a glitch, not a start.
        if (rx_cnt_q == C_HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        // From the start-bit midpoint, a full bit time lands on each data
        // bit's midpoint. LSB arrives first, so shift in from the top.
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == C_DATA_LAST) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == C_BIT_LAST) begin
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Frame-completion strobes, asserted on the stop-bit sample cycle.
  always_comb begin
    rx_good = 1'b0;
    rx_bad  = 1'b0;
    if (rx_state_q == S_STOP && rx_cnt_q == C_BIT_LAST) begin
      rx_good = rx_s2_q;
      rx_bad  = ~rx_s2_q;
    end
  end

  // ------------------------------------------------------------------------
  // CPU-visible flags
  // ------------------------------------------------------------------------
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic              fgi_q,  fgi_d;
  logic              ovr_q,  ovr_d;
  logic              ferr_q, ferr_d;
  logic              ien_q,  ien_d;
  logic              ireq_q, ireq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      ien_q  <= 1'b0;
      ireq_q <= 1'b0;
    end else begin
      inpr_q <= inpr_d;
      fgi_q  <= fgi_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      ien_q  <= ien_d;
      ireq_q <= ireq_d;
    end
  end

  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    ovr_d  = ovr_q;
    if (inp_rd_i) begin
      fgi_d = 1'b0;
      ovr_d = 1'b0;
    end
    // A byte landing on the same edge as INP is the next unread byte, not
    // an overrun: the CPU consumed the previous one on this very edge.
    if (rx_good) begin
      inpr_d = rx_shift_q;
      fgi_d  = 1'b1;
      if (fgi_q && !inp_rd_i) begin
        ovr_d = 1'b1;
      end
    end
    ferr_d = rx_bad;

    ien_d = ien_q;
    if (ien_clr_i || int_ack_i) begin
      ien_d = 1'b0;
    end else if (ien_set_i) begin
      ien_d = 1'b1;
    end

    // Built from current flag registers, so R lags flag changes by a cycle.
    ireq_d = ien_q & (fgi_q | fgo_q);
  end

  assign inpr_o    = inpr_q;
  assign fgi_o     = fgi_q;
  assign fgo_o     = fgo_q;
  assign ien_o     = ien_q;
  assign int_req_o = ireq_q;
  assign ovr_o     = ovr_q;
  assign ferr_o    = ferr_q;

endmodule
`default_nettype wire
